// File: rtl/window_sum_if.sv
// Stream bundle for window_sum: sample input with synchronous clear, plus registered
// window aggregate outputs (sum, fill level, full flag, full-window valid pulse).
interface window_sum_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
);
    localparam int SUM_W = DATA_W + $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [SUM_W-1:0]  out_sum;
    logic              out_full;
    logic [CNT_W-1:0]  fill_count;

    modport master (
        output clear, in_valid, in_data,
        input  out_valid, out_sum, out_full, fill_count
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_valid, out_sum, out_full, fill_count
    );
endinterface

// File: rtl/window_sum.sv
// Sliding-window sum over the last DEPTH accepted samples; outputs registered, 1-cycle latency.
// No backpressure: every valid sample is taken; clear flushes the window and wins over a same-cycle sample.
module window_sum #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    window_sum_if.slave    bus
);
    localparam int SUM_W = DATA_W + $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_W-1:0] r_buf;
    logic [SUM_W-1:0]             r_sum;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_valid;
    logic                         r_full;

    logic                         w_accept;
    logic                         w_at_full;
    logic [SUM_W-1:0]             w_oldest;
    logic [SUM_W-1:0]             w_sum_next;
    logic [CNT_W-1:0]             w_cnt_next;

    assign w_accept   = bus.in_valid & ~bus.clear;
    assign w_at_full  = (r_cnt == CNT_W'(DEPTH));
    // The oldest entry only leaves the sum once the window is already full.
    assign w_oldest   = w_at_full ? SUM_W'(r_buf[DEPTH-1]) : '0;
    assign w_sum_next = r_sum + SUM_W'(bus.in_data) - w_oldest;
    assign w_cnt_next = w_at_full ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else if (bus.clear) begin
            r_buf   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else if (w_accept) begin
            r_buf   <= {r_buf[DEPTH-2:0], bus.in_data};
            r_sum   <= w_sum_next;
            r_cnt   <= w_cnt_next;
            r_valid <= (w_cnt_next == CNT_W'(DEPTH));
            r_full  <= (w_cnt_next == CNT_W'(DEPTH));
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_sum    = r_sum;
    assign bus.fill_count = r_cnt;
    assign bus.out_valid  = r_valid;
    assign bus.out_full   = r_full;
endmodule
